// File: rtl/decode_stage.sv
// MIPS ID stage with ID/EX pipeline register: decode, operand select, load-use stall detection.
// Define WB_BYPASS_EN to forward same-cycle write-back data into the operands.
module decode_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     instr_d,
  input  logic [DATA_W-1:0]     pcplus4_d,
  input  logic                  valid_d,
  input  logic                  flush_e,
  output logic [REG_ADDR_W-1:0] rf_a1,
  output logic [REG_ADDR_W-1:0] rf_a2,
  input  logic [DATA_W-1:0]     rf_rd1,
  input  logic [DATA_W-1:0]     rf_rd2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  stall_d,
  output logic                  valid_e,
  output logic [DATA_W-1:0]     rd1_e,
  output logic [DATA_W-1:0]     rd2_e,
  output logic [DATA_W-1:0]     imm_e,
  output logic [REG_ADDR_W-1:0] rs_e,
  output logic [REG_ADDR_W-1:0] rt_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [DATA_W-1:0]     pcplus4_e,
  output logic                  regwrite_e,
  output logic                  memtoreg_e,
  output logic                  memwrite_e,
  output logic                  branch_e,
  output logic                  alusrc_e,
  output logic                  regdst_e,
  output logic [2:0]            aluctrl_e
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rd_d;
  logic [DATA_W-1:0]     imm_d;
  logic [DATA_W-1:0]     rd1_d, rd2_d;
  logic                  regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d;
  logic [2:0]            aluctrl_d;
  logic                  uses_rt;
  logic                  bubble;

  assign opcode = instr_d[31:26];
  assign funct  = instr_d[5:0];
  assign rs_d   = instr_d[25:21];
  assign rt_d   = instr_d[20:16];
  assign rd_d   = instr_d[15:11];
  assign imm_d  = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
  assign rf_a1  = rs_d;
  assign rf_a2  = rt_d;

  always_comb begin
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    alusrc_d   = 1'b0;
    regdst_d   = 1'b0;
    aluctrl_d  = 3'b000;
    case (opcode)
      OpRtype: begin
        // Unknown funct decodes as a NOP: no controls asserted.
        case (funct)
          6'h20: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluctrl_d = AluAdd; end
          6'h22: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluctrl_d = AluSub; end
          6'h24: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluctrl_d = AluAnd; end
          6'h25: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluctrl_d = AluOr;  end
          6'h2a: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluctrl_d = AluSlt; end
          default: ;
        endcase
      end
      OpLw: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
        alusrc_d   = 1'b1;
        aluctrl_d  = AluAdd;
      end
      OpSw: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        aluctrl_d  = AluAdd;
      end
      OpBeq: begin
        branch_d  = 1'b1;
        aluctrl_d = AluSub;
      end
      OpAddi: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        aluctrl_d  = AluAdd;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rf_a1 != '0) begin
      rd1_d = rf_rd1;
`ifdef WB_BYPASS_EN
      if (wb_we && (wb_addr == rf_a1)) rd1_d = wb_data;
`endif
    end
    if (rf_a2 != '0) begin
      rd2_d = rf_rd2;
`ifdef WB_BYPASS_EN
      if (wb_we && (wb_addr == rf_a2)) rd2_d = wb_data;
`endif
    end
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  // Only R-type, sw and beq actually read rt as a source.
  assign uses_rt = (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBeq);

  assign stall_d = valid_e && memtoreg_e && (rt_e != '0) && valid_d &&
                   ((rt_e == rs_d) || (uses_rt && (rt_e == rt_d)));

  assign bubble = flush_e || stall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      pcplus4_e  <= '0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      aluctrl_e  <= 3'b000;
    end else begin
      // Data fields load unconditionally; consumers qualify them with valid_e.
      rd1_e     <= rd1_d;
      rd2_e     <= rd2_d;
      imm_e     <= imm_d;
      rs_e      <= rs_d;
      rt_e      <= rt_d;
      rd_e      <= rd_d;
      pcplus4_e <= pcplus4_d;
      if (bubble || !valid_d) begin
        valid_e    <= 1'b0;
        regwrite_e <= 1'b0;
        memtoreg_e <= 1'b0;
        memwrite_e <= 1'b0;
        branch_e   <= 1'b0;
        alusrc_e   <= 1'b0;
        regdst_e   <= 1'b0;
        aluctrl_e  <= 3'b000;
      end else begin
        valid_e    <= 1'b1;
        regwrite_e <= regwrite_d;
        memtoreg_e <= memtoreg_d;
        memwrite_e <= memwrite_d;
        branch_e   <= branch_d;
        alusrc_e   <= alusrc_d;
        regdst_e   <= regdst_d;
        aluctrl_e  <= aluctrl_d;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes expected responses from an
// instruction-level model, a monitor pops and compares them against the DUT.
module tb_decode_stage;

`ifdef WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] instr_d, pcplus4_d, rf_rd1, rf_rd2, wb_data;
  logic        valid_d, flush_e, wb_we;
  logic [4:0]  wb_addr;
  logic [4:0]  rf_a1, rf_a2, rs_e, rt_e, rd_e;
  logic        stall_d, valid_e, regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, regdst_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pcplus4_e;
  logic [2:0]  aluctrl_e;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .flush_e(flush_e), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall_d(stall_d), .valid_e(valid_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .pcplus4_e(pcplus4_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .memwrite_e(memwrite_e), .branch_e(branch_e), .alusrc_e(alusrc_e), .regdst_e(regdst_e),
    .aluctrl_e(aluctrl_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [4:0]  a1, a2;
    logic        valid, regwrite, memtoreg, memwrite, branch, alusrc, regdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs, rt, rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        ex_m;
  logic [31:0] regs[32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t decode(input logic [31:0] ins);
    exp_t e = '0;
    case (ins[31:26])
      6'd0: begin
        e.regwrite = 1'b1;
        e.regdst   = 1'b1;
        if      (ins[5:0] == 6'h20) e.alu = 3'b010;
        else if (ins[5:0] == 6'h22) e.alu = 3'b110;
        else if (ins[5:0] == 6'h24) e.alu = 3'b000;
        else if (ins[5:0] == 6'h25) e.alu = 3'b001;
        else if (ins[5:0] == 6'h2a) e.alu = 3'b111;
        else begin e.regwrite = 1'b0; e.regdst = 1'b0; end
      end
      6'd35: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; e.alusrc = 1'b1; e.alu = 3'b010; end
      6'd43: begin e.memwrite = 1'b1; e.alusrc = 1'b1; e.alu = 3'b010; end
      6'd4:  begin e.branch = 1'b1; e.alu = 3'b110; end
      6'd8:  begin e.regwrite = 1'b1; e.alusrc = 1'b1; e.alu = 3'b010; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (Byp && we && wa == a) return wd;
    return regs[a];
  endfunction

  // One ID cycle: drive inputs, predict stall and next EX contents, then advance past the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, output logic st);
    exp_t       e;
    logic [4:0] rs, rt;
    logic [5:0] op;
    logic       uses_rt;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    instr_d = ins; pcplus4_d = pc; valid_d = v; flush_e = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    rf_rd1 = regs[rs]; rf_rd2 = regs[rt];
    uses_rt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
    st = ex_m.valid && ex_m.memtoreg && ex_m.rt != 0 && v &&
         (ex_m.rt == rs || (uses_rt && ex_m.rt == rt));
    e = decode(ins);
    if (!v || fl || st) begin
      e = '0;
    end else begin
      e.valid = 1'b1;
    end
    e.rd1 = opnd(rs, we, wa, wd);
    e.rd2 = opnd(rt, we, wa, wd);
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.pc = pc; e.rs = rs; e.rt = rt; e.rd = ins[15:11];
    e.stall = st; e.a1 = rs; e.a2 = rt;
    sb.push_back(e);
    ex_m = e;
    @(posedge clk);
    if (we && wa != 0) regs[wa] = wd;
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_d", 32'(stall_d), 32'(e.stall));
        chk("rf_a1", 32'(rf_a1), 32'(e.a1));
        chk("rf_a2", 32'(rf_a2), 32'(e.a2));
        @(posedge clk);
        #1;
        chk("valid_e", 32'(valid_e), 32'(e.valid));
        chk("ctrl_e", 32'({regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, regdst_e,
                           aluctrl_e}),
            32'({e.regwrite, e.memtoreg, e.memwrite, e.branch, e.alusrc, e.regdst, e.alu}));
        if (e.valid) begin
          chk("rd1_e", rd1_e, e.rd1);
          chk("rd2_e", rd2_e, e.rd2);
          chk("imm_e", imm_e, e.imm);
          chk("pcplus4_e", pcplus4_e, e.pc);
          chk("regs_e", 32'({rs_e, rt_e, rd_e}), 32'({e.rs, e.rt, e.rd}));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 6))
      0, 1:    op = 6'd0;
      2:       op = 6'd35;
      3:       op = 6'd43;
      4:       op = 6'd4;
      5:       op = 6'd8;
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2a;
      default: fn = 6'($urandom);
    endcase
    if (op == 6'd0) return {op, rs, rt, rd, 5'd0, fn};
    return {op, rs, rt, imm};
  endfunction

  initial begin : driver
    logic        st;
    logic [31:0] ins, pc;
    logic        v;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hFFFF_FFFF;
    ex_m = '0;
    rst = 1'b0;
    // Reset holds EX at zero while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      instr_d = 32'h8CA4_FFFC; pcplus4_d = $urandom; valid_d = 1'b1; flush_e = 1'($urandom);
      rf_rd1 = $urandom; rf_rd2 = $urandom; wb_we = 1'b1; wb_addr = 5'($urandom);
      wb_data = $urandom;
      @(posedge clk);
      #3;
      chk("reset_valid_stall", 32'({valid_e, stall_d}), 32'd0);
      chk("reset_ctrl", 32'({regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, regdst_e,
                             aluctrl_e}), 32'd0);
      chk("reset_data", rd1_e | rd2_e | imm_e | pcplus4_e | 32'({rs_e, rt_e, rd_e}), 32'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;

    regs[1] = 32'd5; regs[2] = 32'd7;
    step(32'h0022_1820, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);    // add $3,$1,$2
    step(32'h8CA4_FFFC, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);    // lw $4,-4($5)
    step(32'h0081_3020, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);    // add $6,$4,$1: stall
    chk("loaduse_stall_seen", 32'(st), 32'd1);
    step(32'h0081_3020, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
    regs[1] = 32'h1111;
    step(32'h0022_1820, 32'h110, 1'b1, 1'b0, 1'b1, 5'd1, 32'hDEAD, st); // WB hits $1
    step(32'h0000_2820, 32'h114, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF, st); // reads of $0
    step(32'h8CA4_FFFC, 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
    step(32'h0081_3020, 32'h11C, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, st);    // flush + stall
    step(32'h0081_3020, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
    step(32'hACAB_0008, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);    // sw

    st = 1'b0; ins = 32'd0; pc = 32'd0; v = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!st) begin
        ins = rand_instr();
        pc = $urandom;
        v = ($urandom_range(0, 9) != 0);
      end
      step(ins, pc, v, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom, st);
    end

    // Asynchronous reset mid-operation clears EX without a clock edge.
    step(32'h2001_0005, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);    // addi $1,$0,5
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset", 32'({valid_e, regwrite_e, alusrc_e, aluctrl_e}), 32'd0);
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
